// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between the fetch port and the load/store port.
// The arbiter alternates grants and runs each transfer as an address phase, a data phase and a one-cycle response, with a bus timeout.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_done,
  output logic                inst_stall,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_done,
  output logic                data_stall,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                bus_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  // Last cycle a granted transfer may spend in ADDR/DATA before it is aborted.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                owner_q;  // 1 = data port
  logic                last_q;   // 1 = data port was served last
  logic [ADDR_W-1:0]   addr_q;
  logic                wr_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [7:0]          cnt_q;
  logic                err_q;
  logic [DATA_W-1:0]   irdata_q, drdata_q;

  logic any_req, grant_data, busy, hit, abort;

  assign any_req    = inst_req | data_req;
  assign grant_data = data_req & (~inst_req | ~last_q);
  assign busy       = (state_q == ADDR) | (state_q == DATA);
  assign hit        = ((state_q == ADDR) & bus_addr_ok & bus_data_ok) |
                      ((state_q == DATA) & bus_data_ok);
  assign abort      = busy & ~hit & (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (any_req) state_d = ADDR;
      ADDR: begin
        if (hit || abort)     state_d = RESP;
        else if (bus_addr_ok) state_d = DATA;
      end
      DATA: if (hit || abort) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_req   = (state_q == ADDR);
    inst_done = (state_q == RESP) & ~owner_q;
    data_done = (state_q == RESP) & owner_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= 1'b0;
      last_q   <= 1'b0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      if (state_q == IDLE && any_req) begin
        owner_q <= grant_data;
        addr_q  <= grant_data ? data_addr : inst_addr;
        wr_q    <= grant_data & data_wr;
        wstrb_q <= (grant_data & data_wr) ? data_wstrb : '0;
        wdata_q <= grant_data ? data_wdata : '0;
        cnt_q   <= '0;
      end
      if (busy) cnt_q <= cnt_q + 8'd1;
      // Load results land on the edge into RESP so rdata is valid with done.
      if (hit && !wr_q) begin
        if (owner_q) drdata_q <= bus_rdata;
        else         irdata_q <= bus_rdata;
      end
      if (abort) begin
        err_q <= 1'b1;
        if (owner_q) drdata_q <= '0;
        else         irdata_q <= '0;
      end
      if (state_q == RESP) last_q <= owner_q;
    end
  end

  assign inst_stall = inst_req & ~inst_done;
  assign data_stall = data_req & ~data_done;
  assign inst_rdata = irdata_q;
  assign data_rdata = drdata_q;
  assign bus_wr     = wr_q;
  assign bus_wstrb  = wstrb_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign bus_err    = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vectors, hand sequences for arbitration and reset,
// and random traffic against a transaction-level timing model.
module tb_mem_bus_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_done, inst_stall;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_done, data_stall;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok, bus_err;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_done(inst_done), .inst_stall(inst_stall),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_done(data_done), .data_stall(data_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          a;     // ADDR cycles before addr_ok
    int          d;     // further cycles until data_ok
    logic [31:0] word;
    int          lat;   // cycles from request to done, request cycle = 1
    logic [31:0] rd;
    bit          err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int n, k;
    bit got, eb, odone, ostall, xdone;
    logic [31:0] ord;
    idle_inputs();
    if (v.is_d) begin
      data_req = 1'b1; data_wr = v.wr; data_addr = v.addr; data_wdata = v.wdata; data_wstrb = v.strb;
    end else begin
      inst_req = 1'b1; inst_addr = v.addr;
    end
    bus_rdata = v.word;
    n = 1; got = 1'b0;
    while (!got && n <= 30) begin
      k = n - 2;
      bus_addr_ok = (k == v.a);
      bus_data_ok = (k >= 0 && k == v.a + v.d);
      #1;
      eb = (k >= 0 && k <= v.a && k <= TO - 1);
      chk("vec_bus_req", 32'(bus_req), 32'(eb));
      if (eb) begin
        chk("vec_bus_addr", bus_addr, v.addr);
        chk("vec_bus_wr", 32'(bus_wr), 32'(v.is_d && v.wr));
        chk("vec_bus_wstrb", 32'(bus_wstrb), (v.is_d && v.wr) ? 32'(v.strb) : 32'h0);
        if (!v.is_d || v.wr) chk("vec_bus_wdata", bus_wdata, v.is_d ? v.wdata : 32'h0);
      end
      odone  = v.is_d ? data_done : inst_done;
      ostall = v.is_d ? data_stall : inst_stall;
      xdone  = v.is_d ? inst_done : data_done;
      ord    = v.is_d ? data_rdata : inst_rdata;
      chk("vec_other_done", 32'(xdone), 32'h0);
      if (odone) begin
        got = 1'b1;
        chk("vec_latency", 32'(n), 32'(v.lat));
        chk("vec_rdata", ord, v.rd);
        chk("vec_err", 32'(bus_err), 32'(v.err));
        chk("vec_stall_done", 32'(ostall), 32'h0);
      end else begin
        chk("vec_stall_wait", 32'(ostall), 32'h1);
        step();
        n++;
      end
    end
    if (!got) begin
      bad++;
      $display("FAIL vec_done_timeout: got none want done by cycle %0d", v.lat);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    int ea, ed, c, k, astart, resp_at;
    bit busy, own, to, last_d, i_pend, d_pend, ebr, done_now, e_wr;
    logic [31:0] e_addr, e_wdata, word, eir, edr;
    logic [3:0] e_strb;
    bit er;

    vecs[0] = '{1'b0, 1'b0, 32'hBFC00000, 32'h0,        4'h0, 0,  0,  32'h3C011234, 3,  32'h3C011234, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h80000010, 32'hAABBCCDD, 4'h3, 2,  3,  32'h0BADBEEF, 8,  32'h0,        1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h00001000, 32'h0,        4'h0, 1,  0,  32'h12345678, 4,  32'h12345678, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h00400004, 32'h0,        4'h0, 0,  2,  32'hCAFEF00D, 5,  32'hCAFEF00D, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'h00001004, 32'h11223344, 4'hF, 0,  1,  32'h55555555, 4,  32'h12345678, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h00002000, 32'h0,        4'h0, 20, 0,  32'h77777777, 10, 32'h0,        1'b1};
    vecs[6] = '{1'b0, 1'b0, 32'h00400008, 32'h0,        4'h0, 1,  20, 32'h88888888, 10, 32'h0,        1'b1};
    vecs[7] = '{1'b0, 1'b0, 32'h0040000C, 32'h0,        4'h0, 0,  0,  32'h24020001, 3,  32'h24020001, 1'b1};

    do_reset();
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_bus_wr", 32'(bus_wr), 32'h0);
    chk("rst_bus_wstrb", 32'(bus_wstrb), 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_inst_done", 32'(inst_done), 32'h0);
    chk("rst_data_done", 32'(data_done), 32'h0);
    chk("rst_inst_rdata", inst_rdata, 32'h0);
    chk("rst_data_rdata", data_rdata, 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);

    // Both ports requesting continuously with an instant slave: D, I, D, I every 3 cycles.
    inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h100; data_addr = 32'h200;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h5A5A0000;
    for (int n = 1; n <= 12; n++) begin
      #1;
      chk("alt_data_done", 32'(data_done), 32'(n % 6 == 3));
      chk("alt_inst_done", 32'(inst_done), 32'(n % 6 == 0));
      if (n % 3 == 2) chk("alt_bus_addr", bus_addr, (n % 6 == 2) ? 32'h200 : 32'h100);
      step();
    end
    idle_inputs();
    step();

    // Reset while waiting in the data phase.
    data_req = 1'b1; data_addr = 32'h300;
    step();
    bus_addr_ok = 1'b1;
    #1;
    chk("rd_addr_phase", 32'(bus_req), 32'h1);
    step();
    bus_addr_ok = 1'b0;
    #1;
    chk("rd_data_phase_req", 32'(bus_req), 32'h0);
    chk("rd_pre_rdata", data_rdata, 32'h5A5A0000);
    chk("rd_pre_stall", 32'(data_stall), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0; data_req = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEADDEAD;
    #1;
    chk("rd_bus_req", 32'(bus_req), 32'h0);
    chk("rd_data_rdata", data_rdata, 32'h0);
    chk("rd_inst_rdata", inst_rdata, 32'h0);
    for (int n = 0; n < 3; n++) begin
      chk("rd_no_data_done", 32'(data_done), 32'h0);
      chk("rd_no_inst_done", 32'(inst_done), 32'h0);
      chk("rd_late_rdata", data_rdata, 32'h0);
      step();
    end
    idle_inputs();
    step();

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    do_reset();
    #1;
    chk("rst2_bus_err", 32'(bus_err), 32'h0);

    // Random traffic. Each granted transfer gets slave delays chosen here, which fix
    // its response cycle arithmetically: ADDR starts the cycle after grant, done
    // follows completion (addr delay + data delay) or the timeout limit.
    busy = 1'b0; last_d = 1'b0; i_pend = 1'b0; d_pend = 1'b0; er = 1'b0;
    eir = '0; edr = '0; astart = -100; resp_at = -100; ea = 0; ed = 0; c = 0;
    own = 1'b0; to = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0; e_strb = '0; word = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!i_pend) begin
        inst_req = ($urandom_range(0, 2) != 0); inst_addr = $urandom; i_pend = inst_req;
      end
      if (!d_pend) begin
        data_req = ($urandom_range(0, 2) != 0); data_wr = 1'($urandom_range(0, 1));
        data_wstrb = 4'($urandom); data_addr = $urandom; data_wdata = $urandom; d_pend = data_req;
      end
      if (!busy && (inst_req || data_req)) begin
        own = data_req && (!inst_req || last_d);
        own = data_req && (!inst_req || !last_d);
        ea = $urandom_range(0, 5); ed = $urandom_range(0, 4); c = ea + ed; to = (c > TO - 1);
        astart = cyc + 1; resp_at = astart + 1 + (to ? TO - 1 : c); busy = 1'b1; word = $urandom;
        e_addr = own ? data_addr : inst_addr; e_wr = own && data_wr;
        e_strb = e_wr ? data_wstrb : 4'h0; e_wdata = own ? data_wdata : 32'h0;
      end
      k = cyc - astart;
      if (busy && k >= 0 && cyc < resp_at) begin
        bus_addr_ok = (k == ea); bus_data_ok = (k == c); bus_rdata = (k == c) ? word : $urandom;
      end else begin
        bus_addr_ok = 1'b0; bus_data_ok = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
      end
      #1;
      ebr = busy && k >= 0 && k <= ea && k <= TO - 1 && cyc < resp_at;
      done_now = busy && cyc == resp_at;
      if (done_now) begin
        if (to) begin
          er = 1'b1;
          if (own) edr = '0; else eir = '0;
        end else if (!own) eir = word;
        else if (!e_wr) edr = word;
      end
      chk("rnd_bus_req", 32'(bus_req), 32'(ebr));
      if (ebr) begin
        chk("rnd_bus_addr", bus_addr, e_addr);
        chk("rnd_bus_wr", 32'(bus_wr), 32'(e_wr));
        chk("rnd_bus_wstrb", 32'(bus_wstrb), 32'(e_strb));
        if (!own || e_wr) chk("rnd_bus_wdata", bus_wdata, e_wdata);
      end
      chk("rnd_inst_done", 32'(inst_done), 32'(done_now && !own));
      chk("rnd_data_done", 32'(data_done), 32'(done_now && own));
      chk("rnd_inst_stall", 32'(inst_stall), 32'(inst_req && !(done_now && !own)));
      chk("rnd_data_stall", 32'(data_stall), 32'(data_req && !(done_now && own)));
      chk("rnd_inst_rdata", inst_rdata, eir);
      chk("rnd_data_rdata", data_rdata, edr);
      chk("rnd_bus_err", 32'(bus_err), 32'(er));
      if (done_now) begin
        busy = 1'b0; last_d = own;
        if (own) d_pend = 1'b0; else i_pend = 1'b0;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory bus between the fetch-stage instruction port (pcF/instrF, read-only) and the mem-stage data port (aluoutM/writedataM/readdataM, read/write).
- Sits between the pipelined datapath and the memory/bridge.
- Serialises transactions through an address-phase / data-phase FSM.
- Returns per-port done pulses and stall levels for the hazard unit, and flags bus timeouts.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; the write strobe is DATA_W/8 bits.
- TIMEOUT, 255, max cycles a granted transaction may stay in ADDR+DATA before it is aborted; counter is 8 bits.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_req  in  1  fetch request; held high until inst_done.
- inst_addr  in  ADDR_W  fetch address (pcF).
- inst_rdata  out  DATA_W  fetched word; valid while inst_done=1, then held.
- inst_done  out  1  one-cycle completion pulse.
- inst_stall  out  1  inst_req & ~inst_done.
- data_req  in  1  load/store request; held until data_done.
- data_wr  in  1  1 = store.
- data_wstrb  in  DATA_W/8  byte enables for a store.
- data_addr  in  ADDR_W  load/store address.
- data_wdata  in  DATA_W  store data.
- data_rdata  out  DATA_W  load result; valid while data_done=1, then held.
- data_done  out  1  one-cycle completion pulse.
- data_stall  out  1  data_req & ~data_done.
- bus_req  out  1  address-phase request.
- bus_wr  out  1  bus write flag.
- bus_wstrb  out  DATA_W/8  bus byte enables; 0 for reads.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_addr_ok  in  1  slave accepted the address.
- bus_data_ok  in  1  slave completed the transfer; bus_rdata valid.
- bus_rdata  in  DATA_W  bus read data.
- bus_err  out  1  sticky timeout flag.

Behaviour:

Reset:
- Synchronous, active-high; all outputs and registers take their reset values on the rising edge with rst=1.
- state=IDLE, owner=INST, last=INST; bus_* outputs all 0.
- inst_rdata=data_rdata=0, done pulses=0, bus_err=0, timeout counter=0.
- A transaction in flight when rst asserts is abandoned with no done pulse. The slave is reset on the same rst.

FSM states: IDLE, ADDR, DATA, RESP.

IDLE:
- No request: stay in IDLE.
- Grant when either request is high:
  - data_req only: data port wins.
  - inst_req only: inst port wins.
  - Both high: the port opposite to `last` wins. After reset data wins first.
- On grant: latch owner, addr, wr, wstrb, wdata into bus registers (inst: wr=0, wstrb=0, wdata=0). Clear the counter. Go to ADDR.
- Requester inputs are not sampled again until the next IDLE.

ADDR:
- bus_req=1 with the latched fields stable.
- bus_addr_ok=1 and bus_data_ok=1 in the same cycle: capture bus_rdata and go to RESP, skipping DATA.
- bus_addr_ok=1 only: go to DATA.
- Otherwise stay.

DATA:
- bus_req=0.
- On bus_data_ok: capture bus_rdata (reads only) and go to RESP.
- bus_data_ok outside ADDR/DATA is ignored.

RESP, one cycle:
- Owner's done=1. Owner's rdata = captured word on reads; unchanged on writes. Non-owner's outputs unchanged.
- last=owner. Next state is always IDLE; RESP never grants, so a requester that is still dropping req cannot be regranted.

Latency:
- Best case is 3 cycles from req-high-in-IDLE to done: IDLE, ADDR (with addr_ok and data_ok together), RESP.
- Back-to-back transactions: one grant every 3 cycles minimum.

Timeout:
- The counter increments each cycle in ADDR or DATA.
- When it reaches TIMEOUT with no completion: set bus_err (sticky until rst), drop bus_req, go to RESP, and the owner's rdata=0.

Stall outputs:
- Combinational; they fall in the done cycle so the pipeline advances on that edge.

Test Plan:
- Single fetch: inst_req=1, inst_addr=0xBFC00000; slave returns addr_ok and data_ok in ADDR with rdata 0x3C011234 -> bus_addr=0xBFC00000, bus_wr=0; inst_done pulses in cycle 3 with inst_rdata=0x3C011234; inst_stall is 1 in cycles 1-2 and 0 in cycle 3.
- Store with wait states: data_wr=1, wstrb=0x3, addr=0x80000010, wdata=0xAABBCCDD; addr_ok after 2 cycles, data_ok after 3 more -> bus fields stable through ADDR; a single data_done; data_rdata unchanged.
- Simultaneous requests after reset: both req high -> data granted first, inst granted in the next IDLE. Alternation repeats when both stay requesting (grant order D, I, D, I).
- Timeout with TIMEOUT=4: slave never responds -> after 4 cycles bus_req=0, owner done pulse, rdata=0, bus_err=1 and held 1 across later transactions until rst.
- Reset in DATA: assert rst while waiting for data_ok -> next cycle state IDLE, bus_req=0, no done pulses, rdata registers=0; a late bus_data_ok is ignored.
- Held request after done: requester keeps inst_req high one cycle past inst_done -> no regrant in RESP; a new grant occurs in IDLE only if inst_req is still high there.
